// File: rtl/cdf_equalize_lut.sv
// rtl/cdf_equalize_lut.sv - CDF to 8-bit equalization LUT generator
//
// Reads the 256-entry CDF table (4 x 32-bit bins per 128-bit word) from
// scratch memory, maps every bin to round((cdf-cdf_min)*255/(pixel_count-cdf_min))
// and writes the 256 results back as 16 x 128-bit LUT words.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               1-cycle request, ignored while busy
//   cdf_min, pixel_count normalisation constants, latched on start
//   ReadAddress/ReadData scratch-memory read port (data valid 2 edges after address)
//   WE/WriteAddress/WriteBus scratch-memory write port, one pulse per LUT word
//   busy, done          run status, done pulses once after the last write
module cdf_equalize_lut #(
    parameter int CDF_BASE = 64,
    parameter int LUT_BASE = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  cdf_min,
    input  logic [31:0]  pixel_count,
    output logic [15:0]  ReadAddress,
    input  logic [127:0] ReadData,
    output logic         WE,
    output logic [15:0]  WriteAddress,
    output logic [127:0] WriteBus,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, BIN_SETUP, DIV, WR, DONE
    } state_t;

    state_t state, next_state;

    logic [31:0]  cmin, pcnt;
    logic [5:0]   w;
    logic [1:0]   b;
    logic [2:0]   k;
    logic [127:0] word;
    logic [127:0] lut;
    logic [40:0]  rem;
    logic [40:0]  dsh;
    logic [7:0]   quo;
    logic         forced;
    logic [7:0]   forced_val;

    logic [31:0]  cdf_sel, den_c, diff_c;
    logic [40:0]  num_c;
    logic         ge;
    logic [40:0]  rem_next;
    logic [7:0]   quo_next;
    logic [7:0]   bin_res;
    logic [127:0] lut_next;
    logic [15:0]  next_rd_addr;

    // Bin 4w+0 sits in the most significant slice of the CDF word.
    always_comb begin
        cdf_sel = word[31:0];
        case (b)
            2'd0: cdf_sel = word[127:96];
            2'd1: cdf_sel = word[95:64];
            2'd2: cdf_sel = word[63:32];
            2'd3: cdf_sel = word[31:0];
            default: cdf_sel = word[31:0];
        endcase
    end

    // (cdf-cdf_min)*255 + den/2 fits in 41 bits for any 32-bit operands.
    always_comb begin
        den_c  = pcnt - cmin;
        diff_c = cdf_sel - cmin;
        num_c  = ({9'd0, diff_c} << 8) - {9'd0, diff_c} + {10'd0, den_c[31:1]};
    end

    // One restoring-division step per DIV cycle; dsh holds den << (7-k).
    always_comb begin
        ge        = (rem >= dsh);
        rem_next  = ge ? (rem - dsh) : rem;
        quo_next  = {quo[6:0], ge};
        bin_res   = forced ? forced_val : quo_next;
        // Shifting in from the right leaves bin 16j+0 in the MSB byte after 16 bins.
        lut_next  = {lut[119:0], bin_res};
        next_rd_addr = 16'(CDF_BASE) + {10'd0, w + 6'd1};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = RD_ISSUE;
            RD_ISSUE:  next_state = RD_WAIT;
            RD_WAIT:   next_state = BIN_SETUP;
            BIN_SETUP: next_state = DIV;
            DIV: begin
                if (k == 3'd7) begin
                    if (b != 2'd3)           next_state = BIN_SETUP;
                    else if (w[1:0] != 2'd3) next_state = RD_ISSUE;
                    else                     next_state = WR;
                end
            end
            WR:        next_state = (w == 6'd63) ? DONE : RD_ISSUE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmin         <= '0;
            pcnt         <= '0;
            w            <= '0;
            b            <= '0;
            k            <= '0;
            word         <= '0;
            lut          <= '0;
            rem          <= '0;
            dsh          <= '0;
            quo          <= '0;
            forced       <= 1'b0;
            forced_val   <= '0;
            ReadAddress  <= '0;
            WE           <= 1'b0;
            WriteAddress <= '0;
            WriteBus     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            WE   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmin        <= cdf_min;
                        pcnt        <= pixel_count;
                        w           <= '0;
                        b           <= '0;
                        busy        <= 1'b1;
                        ReadAddress <= 16'(CDF_BASE);
                    end
                end
                RD_WAIT: begin
                    word <= ReadData;
                end
                BIN_SETUP: begin
                    rem <= num_c;
                    dsh <= {2'b00, den_c, 7'd0};
                    quo <= '0;
                    k   <= '0;
                    if (cdf_sel < cmin) begin
                        forced     <= 1'b1;
                        forced_val <= 8'd0;
                    end else if (cdf_sel >= pcnt || den_c == 32'd0) begin
                        forced     <= 1'b1;
                        forced_val <= 8'd255;
                    end else begin
                        forced     <= 1'b0;
                        forced_val <= 8'd0;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    dsh <= dsh >> 1;
                    quo <= quo_next;
                    k   <= k + 3'd1;
                    if (k == 3'd7) begin
                        lut <= lut_next;
                        if (b != 2'd3) begin
                            b <= b + 2'd1;
                        end else if (w[1:0] != 2'd3) begin
                            w           <= w + 6'd1;
                            b           <= '0;
                            ReadAddress <= next_rd_addr;
                        end else begin
                            WE           <= 1'b1;
                            WriteAddress <= 16'(LUT_BASE) + {12'd0, w[5:2]};
                            WriteBus     <= lut_next;
                        end
                    end
                end
                WR: begin
                    if (w == 6'd63) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        w           <= w + 6'd1;
                        b           <= '0;
                        ReadAddress <= next_rd_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
